// File: rtl/ccip_event_trace.sv
// CCI-P event trace: ring buffer of Tx/Rx events with an mdata or
// error-edge trigger, post-trigger window and saturating channel counters.
package ccip_trace_pkg;
  typedef struct packed {
    logic [15:0] mdata;
  } t_ccip_Hdr;

  typedef struct packed {
    t_ccip_Hdr hdr;
    logic      valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_Hdr hdr;
    logic      valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic mmioRdValid;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef struct packed {
    t_ccip_Hdr hdr;
    logic      rspValid;
    logic      mmioRdValid;
    logic      mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_Hdr hdr;
    logic      rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module ccip_event_trace
  import ccip_trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int POST_TRIG = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          pClk,
  input  logic          pck_cp2af_softReset,
  input  logic          pck_cp2af_error,
  input  t_if_ccip_Rx   pck_cp2af_sRx,
  input  t_if_ccip_Tx   pck_af2cp_sTx,
  input  logic          arm,
  input  logic [15:0]   trig_mdata,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic [1:0]    trc_state,
  output logic [AW-1:0] trig_ptr,
  output logic [AW-1:0] wr_ptr,
  output logic [31:0]   cnt_c0tx,
  output logic [31:0]   cnt_c1tx,
  output logic [31:0]   cnt_c0rsp,
  output logic [31:0]   cnt_c1rsp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trcState_e;

  trcState_e     state;
  logic [12:0]   ts;
  logic          errQ;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] trigPtr;
  logic [AW-1:0] postCnt;
  logic [31:0]   c0TxCnt;
  logic [31:0]   c1TxCnt;
  logic [31:0]   c0RspCnt;
  logic [31:0]   c1RspCnt;
  logic [31:0]   mem [DEPTH];

  logic [7:1]  ev;
  logic [2:0]  evCode;
  logic [15:0] evMdata;
  logic        anyEv;
  logic        errEdge;
  logic        trigHit;
  logic        capWr;
  logic [31:0] entry;

  assign ev = {pck_af2cp_sTx.c2.mmioRdValid,
               pck_cp2af_sRx.c0.mmioRdValid,
               pck_cp2af_sRx.c0.mmioWrValid,
               pck_cp2af_sRx.c1.rspValid,
               pck_cp2af_sRx.c0.rspValid,
               pck_af2cp_sTx.c1.valid,
               pck_af2cp_sTx.c0.valid};

  // Lowest code wins when several events land in one cycle
  always_comb begin
    evCode  = 3'd0;
    evMdata = 16'h0;
    if (ev[1]) begin
      evCode  = 3'd1;
      evMdata = pck_af2cp_sTx.c0.hdr.mdata;
    end else if (ev[2]) begin
      evCode  = 3'd2;
      evMdata = pck_af2cp_sTx.c1.hdr.mdata;
    end else if (ev[3]) begin
      evCode  = 3'd3;
      evMdata = pck_cp2af_sRx.c0.hdr.mdata;
    end else if (ev[4]) begin
      evCode  = 3'd4;
      evMdata = pck_cp2af_sRx.c1.hdr.mdata;
    end else if (ev[5]) begin
      evCode  = 3'd5;
    end else if (ev[6]) begin
      evCode  = 3'd6;
    end else if (ev[7]) begin
      evCode  = 3'd7;
    end
  end

  assign anyEv   = |ev;
  assign errEdge = pck_cp2af_error & ~errQ;
  assign trigHit = (pck_af2cp_sTx.c0.valid &&
                    pck_af2cp_sTx.c0.hdr.mdata == trig_mdata) ||
                   errEdge;
  assign entry   = {evCode, evMdata, ts};
  // A bare error edge still leaves a code-0 marker entry
  assign capWr   = !arm &&
                   ((state == ARMED && (anyEv || trigHit)) ||
                    (state == POST && anyEv));

  function automatic logic [31:0] satInc(input logic [31:0] c,
                                         input logic v);
    return (v && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
  endfunction

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      ts   <= 13'd0;
      errQ <= 1'b0;
    end else begin
      ts   <= ts + 13'd1;
      errQ <= pck_cp2af_error;
    end
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      c0TxCnt  <= 32'd0;
      c1TxCnt  <= 32'd0;
      c0RspCnt <= 32'd0;
      c1RspCnt <= 32'd0;
    end else if (arm) begin
      c0TxCnt  <= 32'd0;
      c1TxCnt  <= 32'd0;
      c0RspCnt <= 32'd0;
      c1RspCnt <= 32'd0;
    end else begin
      c0TxCnt  <= satInc(c0TxCnt, ev[1]);
      c1TxCnt  <= satInc(c1TxCnt, ev[2]);
      c0RspCnt <= satInc(c0RspCnt, ev[3]);
      c1RspCnt <= satInc(c1RspCnt, ev[4]);
    end
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      state   <= IDLE;
      wrPtr   <= '0;
      trigPtr <= '0;
      postCnt <= '0;
    end else if (arm) begin
      state   <= ARMED;
      wrPtr   <= '0;
      postCnt <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        ARMED: begin
          if (capWr) wrPtr <= wrPtr + AW'(1);
          if (trigHit) begin
            trigPtr <= wrPtr;
            state   <= POST;
          end
        end
        POST: begin
          if (anyEv) begin
            wrPtr <= wrPtr + AW'(1);
            if (postCnt == AW'(POST_TRIG - 1)) state <= DONE;
            else postCnt <= postCnt + AW'(1);
          end
        end
        DONE: ;
      endcase
    end
  end

  always_ff @(posedge pClk) begin
    if (capWr) mem[wrPtr] <= entry;
  end

  // Registered read sees pre-write contents on a same-index collision
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= mem[rd_idx];
    end
  end

  assign trc_state = state;
  assign trig_ptr  = trigPtr;
  assign wr_ptr    = wrPtr;
  assign cnt_c0tx  = c0TxCnt;
  assign cnt_c1tx  = c1TxCnt;
  assign cnt_c0rsp = c0RspCnt;
  assign cnt_c1rsp = c1RspCnt;

endmodule

// File: tb/tb_ccip_event_trace.sv
// Bench for ccip_event_trace: directed scenarios plus random traffic
// checked against a capture-log model of the trace buffer.
module tb_ccip_event_trace;
  import ccip_trace_pkg::*;

  localparam int DEPTH = 64;
  localparam int POST_TRIG = 16;
  localparam int AW = 6;

  logic pClk = 1'b0;
  always #5 pClk = ~pClk;

  logic          rst = 1'b1;
  logic          err = 1'b0;
  logic          arm = 1'b0;
  logic          rdReq = 1'b0;
  logic [15:0]   trigM = 16'h0;
  logic [AW-1:0] rdIdx = '0;
  t_if_ccip_Rx   rx;
  t_if_ccip_Tx   tx;

  logic          rdValid;
  logic [31:0]   rdData;
  logic [1:0]    trcState;
  logic [AW-1:0] trigPtr;
  logic [AW-1:0] wrPtr;
  logic [31:0]   cC0tx, cC1tx, cC0rsp, cC1rsp;

  int passed = 0;
  int total = 0;

  ccip_event_trace #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .pClk(pClk),
    .pck_cp2af_softReset(rst),
    .pck_cp2af_error(err),
    .pck_cp2af_sRx(rx),
    .pck_af2cp_sTx(tx),
    .arm(arm),
    .trig_mdata(trigM),
    .rd_req(rdReq),
    .rd_idx(rdIdx),
    .rd_valid(rdValid),
    .rd_data(rdData),
    .trc_state(trcState),
    .trig_ptr(trigPtr),
    .wr_ptr(wrPtr),
    .cnt_c0tx(cC0tx),
    .cnt_c1tx(cC1tx),
    .cnt_c0rsp(cC0rsp),
    .cnt_c1rsp(cC1rsp)
  );

  // Model: log of entries written since the last arm
  int          mTs;
  bit          mErrPrev;
  bit          mArmed;
  int          mN;
  int          mTrigAt;
  int          mTrigPtr;
  logic [31:0] mCnt [4];
  logic [31:0] mMem [DEPTH];
  bit          mKnown [DEPTH];
  bit          mRdV;
  logic [31:0] mRdD;
  bit          mRdKnown;

  function automatic int modelState();
    if (!mArmed) return 0;
    if (mTrigAt < 0) return 1;
    if (mN - mTrigAt - 1 >= POST_TRIG) return 3;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic checkAll(input string tag);
    chk({tag, "/state"}, 32'(trcState), 32'(modelState()));
    chk({tag, "/wr_ptr"}, 32'(wrPtr), 32'(mN % DEPTH));
    chk({tag, "/trig_ptr"}, 32'(trigPtr), 32'(mTrigPtr));
    chk({tag, "/c0tx"}, cC0tx, mCnt[0]);
    chk({tag, "/c1tx"}, cC1tx, mCnt[1]);
    chk({tag, "/c0rsp"}, cC0rsp, mCnt[2]);
    chk({tag, "/c1rsp"}, cC1rsp, mCnt[3]);
    chk({tag, "/rd_valid"}, 32'(rdValid), 32'(mRdV));
    if (mRdV && mRdKnown) chk({tag, "/rd_data"}, rdData, mRdD);
  endtask

  task automatic clearIn();
    rx = '0;
    tx = '0;
    arm = 1'b0;
    rdReq = 1'b0;
  endtask

  task automatic tick(input string tag);
    bit [7:1]    v;
    logic [15:0] md [1:7];
    bit          cv [4];
    int          st, code;
    bit          errEdge, trg;
    logic [31:0] ent;
    v = {tx.c2.mmioRdValid, rx.c0.mmioRdValid, rx.c0.mmioWrValid,
         rx.c1.rspValid, rx.c0.rspValid, tx.c1.valid, tx.c0.valid};
    for (int c = 1; c <= 7; c++) md[c] = 16'h0;
    md[1] = tx.c0.hdr.mdata;
    md[2] = tx.c1.hdr.mdata;
    md[3] = rx.c0.hdr.mdata;
    md[4] = rx.c1.hdr.mdata;
    cv = '{v[1], v[2], v[3], v[4]};
    st = modelState();
    mRdV = rdReq;
    if (rdReq) begin
      mRdD = mMem[rdIdx];
      mRdKnown = mKnown[rdIdx];
    end
    errEdge = err && !mErrPrev;
    mErrPrev = err;
    if (arm) begin
      mArmed = 1'b1;
      mN = 0;
      mTrigAt = -1;
      for (int k = 0; k < 4; k++) mCnt[k] = 32'd0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (cv[k] && mCnt[k] != 32'hFFFF_FFFF) mCnt[k] = mCnt[k] + 1;
      if (st == 1 || st == 2) begin
        code = 0;
        for (int c = 7; c >= 1; c--) if (v[c]) code = c;
        trg = (st == 1) &&
              ((v[1] && tx.c0.hdr.mdata == trigM) || errEdge);
        if (code != 0 || trg) begin
          ent = {3'(code), (code >= 1 && code <= 4) ? md[code] : 16'h0,
                 13'(mTs)};
          mMem[mN % DEPTH] = ent;
          mKnown[mN % DEPTH] = 1'b1;
          if (trg) begin
            mTrigAt = mN;
            mTrigPtr = mN % DEPTH;
          end
          mN++;
        end
      end
    end
    mTs = (mTs + 1) % 8192;
    @(posedge pClk);
    #1;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    #2;
    mTs = 0;
    mErrPrev = 1'b0;
    mArmed = 1'b0;
    mN = 0;
    mTrigAt = -1;
    mTrigPtr = 0;
    for (int k = 0; k < 4; k++) mCnt[k] = 32'd0;
    mRdV = 1'b0;
    mRdD = 32'd0;
    mRdKnown = 1'b1;
    checkAll(tag);
    chk({tag, "/rd_data"}, rdData, 32'd0);
    @(posedge pClk);
    #1;
    checkAll(tag);
    @(negedge pClk);
    rst = 1'b0;
  endtask

  task automatic readIdx(input logic [AW-1:0] idx, input string tag);
    rdReq = 1'b1;
    rdIdx = idx;
    tick(tag);
    rdReq = 1'b0;
  endtask

  task automatic doArm();
    clearIn();
    arm = 1'b1;
    tick("arm");
    arm = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mKnown[i] = 1'b0;
    clearIn();
    doReset("reset");

    // 10 c0 Tx without trigger
    trigM = 16'hFFFF;
    doArm();
    for (int i = 0; i < 10; i++) begin
      tx.c0.valid = 1'b1;
      tx.c0.hdr.mdata = 16'(i);
      tick("c0x10");
    end
    clearIn();
    chk("c0x10/wr", 32'(wrPtr), 32'd10);
    chk("c0x10/cnt", cC0tx, 32'd10);
    chk("c0x10/state", 32'(trcState), 32'd1);
    readIdx(6'd3, "rd3");
    chk("rd3/code", 32'(rdData[31:29]), 32'd1);
    chk("rd3/mdata", 32'(rdData[28:13]), 32'd3);

    // wrap, mdata trigger, post window
    trigM = 16'hABCD;
    doArm();
    for (int i = 0; i < 100; i++) begin
      clearIn();
      tx.c1.valid = 1'b1;
      tx.c1.hdr.mdata = 16'($urandom);
      tick("c1x100");
    end
    clearIn();
    tx.c0.valid = 1'b1;
    tx.c0.hdr.mdata = 16'hABCD;
    tick("trig");
    chk("trig/ptr", 32'(trigPtr), 32'd36);
    chk("trig/state", 32'(trcState), 32'd2);
    for (int i = 0; i < 20; i++) begin
      clearIn();
      tx.c1.valid = 1'b1;
      tx.c1.hdr.mdata = 16'($urandom);
      tick("post");
      if (i == 14) chk("post15/state", 32'(trcState), 32'd2);
      if (i == 15) chk("post16/state", 32'(trcState), 32'd3);
    end
    clearIn();
    chk("done/wr", 32'(wrPtr), 32'd53);
    chk("done/c1tx", cC1tx, 32'd120);
    readIdx(6'd36, "rdtrig");
    chk("rdtrig/mdata", 32'(rdData[28:13]), 32'hABCD);

    // same-cycle events
    doArm();
    tx.c0.valid = 1'b1;
    tx.c0.hdr.mdata = 16'h1234;
    rx.c1.rspValid = 1'b1;
    rx.c1.hdr.mdata = 16'h7777;
    rx.c0.mmioWrValid = 1'b1;
    tick("multi");
    clearIn();
    chk("multi/wr", 32'(wrPtr), 32'd1);
    chk("multi/c0tx", cC0tx, 32'd1);
    chk("multi/c1rsp", cC1rsp, 32'd1);
    readIdx(6'd0, "rdmulti");
    chk("rdmulti/code", 32'(rdData[31:29]), 32'd1);
    chk("rdmulti/mdata", 32'(rdData[28:13]), 32'h1234);

    // error-edge trigger without event
    err = 1'b0;
    doArm();
    tick("quiet");
    tick("quiet");
    err = 1'b1;
    tick("errtrig");
    chk("errtrig/state", 32'(trcState), 32'd2);
    chk("errtrig/ptr", 32'(trigPtr), 32'd0);
    readIdx(6'd0, "rderr");
    chk("rderr/codemd", 32'(rdData[31:13]), 32'd0);

    // counter saturation
    force dut.c0TxCnt = 32'hFFFF_FFFD;
    mCnt[0] = 32'hFFFF_FFFD;
    tick("force");
    release dut.c0TxCnt;
    for (int i = 0; i < 3; i++) begin
      clearIn();
      tx.c0.valid = 1'b1;
      tx.c0.hdr.mdata = 16'h0001;
      tick("sat");
    end
    clearIn();
    chk("sat/c0tx", cC0tx, 32'hFFFF_FFFF);

    // random traffic
    trigM = 16'($urandom);
    doArm();
    for (int i = 0; i < 3000; i++) begin
      clearIn();
      arm = ($urandom_range(399) == 0) ||
            (modelState() == 3 && $urandom_range(30) == 0);
      if ($urandom_range(19) == 0) err = ~err;
      tx.c0.valid = ($urandom_range(2) == 0);
      tx.c0.hdr.mdata = ($urandom_range(39) == 0) ? trigM : 16'($urandom);
      tx.c1.valid = ($urandom_range(2) == 0);
      tx.c1.hdr.mdata = 16'($urandom);
      tx.c2.mmioRdValid = ($urandom_range(2) == 0);
      rx.c0.rspValid = ($urandom_range(2) == 0);
      rx.c0.hdr.mdata = 16'($urandom);
      rx.c0.mmioRdValid = ($urandom_range(2) == 0);
      rx.c0.mmioWrValid = ($urandom_range(2) == 0);
      rx.c1.rspValid = ($urandom_range(2) == 0);
      rx.c1.hdr.mdata = 16'($urandom);
      rdReq = 1'($urandom_range(1));
      rdIdx = AW'($urandom);
      tick("rand");
    end
    clearIn();
    err = 1'b0;

    // reset during POST
    trigM = 16'h5555;
    doArm();
    tx.c0.valid = 1'b1;
    tx.c0.hdr.mdata = 16'h5555;
    tick("t45");
    for (int i = 0; i < 3; i++) begin
      clearIn();
      tx.c1.valid = 1'b1;
      tick("p45");
    end
    clearIn();
    chk("p45/state", 32'(trcState), 32'd2);
    doReset("rst45");
    chk("rst45/c1tx", cC1tx, 32'd0);
    for (int i = 0; i < 10; i++) begin
      clearIn();
      tx.c0.valid = 1'b1;
      tx.c1.valid = 1'b1;
      tick("noarm");
    end
    clearIn();
    chk("noarm/wr", 32'(wrPtr), 32'd0);
    chk("noarm/state", 32'(trcState), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
